// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default width
// and the quotient reported on a divide by zero.
package seq_divider_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [WIDTH_DEF-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_if.sv
// Start/done handshake between the execute stage and the sequential divider.
interface div_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the
// partial remainder and produces one quotient bit.
module seq_divider_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // rem < dvs on entry, so the shifted value is < 2*dvs and a successful
  // trial subtract always fits back into WIDTH bits.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign fits      = rem_shift >= {1'b0, dvs};
  assign trial     = rem_shift[WIDTH-1:0] - dvs;
  assign rem_next  = fits ? trial : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], fits};
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, signed (truncating) or unsigned,
// one quotient bit per cycle with a final sign fix-up cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  div_if.slave bus
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             a_neg_in;
  logic             b_neg_in;

  assign a_neg_in = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg_in = bus.is_signed & bus.divisor[WIDTH-1];

  seq_divider_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_mag),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, matching the hardware it infers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      dvs_mag     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            neg_a   <= a_neg_in;
            neg_b   <= b_neg_in;
            dvs_mag <= b_neg_in ? -bus.divisor : bus.divisor;
            rem_q   <= '0;
            cnt     <= '0;
            busy_q  <= 1'b1;
            if (bus.divisor == '0) begin
              // The zero path reports the raw dividend, so park it unmodified.
              quo_q <= bus.dividend;
              state <= ST_DONE;
            end else begin
              quo_q <= a_neg_in ? -bus.dividend : bus.dividend;
              state <= ST_RUN;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          quotient_q  <= (neg_a ^ neg_b) ? -quo_q : quo_q;
          remainder_q <= neg_a ? -rem_q : rem_q;
          dbz_q       <= 1'b0;
          done_q      <= 1'b1;
          state       <= ST_IDLE;
        end
        ST_DONE: begin
          quotient_q  <= WIDTH'(DBZ_QUOTIENT);
          remainder_q <= quo_q;
          dbz_q       <= 1'b1;
          done_q      <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
endmodule
